// File: rtl/eth_tx_arbiter.sv
// Four-requester AXI-Stream round-robin arbiter onto one PHY TX stream, packet-granular grants.
// Optional per-requester packet counters are enabled by defining ARB_PKT_CNT_EN.
module eth_tx_arbiter #(
    parameter int DATA_W = 64
) (
    input  logic                clk156,
    input  logic                rst_n,

    input  logic                s0_tvalid,
    output logic                s0_tready,
    input  logic [DATA_W-1:0]   s0_tdata,
    input  logic [DATA_W/8-1:0] s0_tkeep,
    input  logic                s0_tlast,
    input  logic                s0_tuser,

    input  logic                s1_tvalid,
    output logic                s1_tready,
    input  logic [DATA_W-1:0]   s1_tdata,
    input  logic [DATA_W/8-1:0] s1_tkeep,
    input  logic                s1_tlast,
    input  logic                s1_tuser,

    input  logic                s2_tvalid,
    output logic                s2_tready,
    input  logic [DATA_W-1:0]   s2_tdata,
    input  logic [DATA_W/8-1:0] s2_tkeep,
    input  logic                s2_tlast,
    input  logic                s2_tuser,

    input  logic                s3_tvalid,
    output logic                s3_tready,
    input  logic [DATA_W-1:0]   s3_tdata,
    input  logic [DATA_W/8-1:0] s3_tkeep,
    input  logic                s3_tlast,
    input  logic                s3_tuser,

    output logic                m_tvalid,
    input  logic                m_tready,
    output logic [DATA_W-1:0]   m_tdata,
    output logic [DATA_W/8-1:0] m_tkeep,
    output logic                m_tlast,
    output logic                m_tuser,

`ifdef ARB_PKT_CNT_EN
    output logic [31:0]         pkt_cnt0,
    output logic [31:0]         pkt_cnt1,
    output logic [31:0]         pkt_cnt2,
    output logic [31:0]         pkt_cnt3,
`endif
    output logic [1:0]          grant_id,
    output logic                busy
);

    localparam int KEEP_W = DATA_W / 8;

    typedef enum logic {
        IDLE,
        PKT
    } state_t;

    state_t                  state;
    logic [1:0]              last_grant;
    logic [1:0]              next_grant;
    logic [1:0]              cand;
    logic                    req_found;
    logic                    xfer_last;

    logic [3:0]              s_tvalid;
    logic [3:0]              s_tlast;
    logic [3:0]              s_tuser;
    logic [3:0]              s_tready;
    logic [3:0][DATA_W-1:0]  s_tdata;
    logic [3:0][KEEP_W-1:0]  s_tkeep;

    assign s_tvalid = {s3_tvalid, s2_tvalid, s1_tvalid, s0_tvalid};
    assign s_tlast  = {s3_tlast,  s2_tlast,  s1_tlast,  s0_tlast};
    assign s_tuser  = {s3_tuser,  s2_tuser,  s1_tuser,  s0_tuser};
    assign s_tdata  = {s3_tdata,  s2_tdata,  s1_tdata,  s0_tdata};
    assign s_tkeep  = {s3_tkeep,  s2_tkeep,  s1_tkeep,  s0_tkeep};

    assign s0_tready = s_tready[0];
    assign s1_tready = s_tready[1];
    assign s2_tready = s_tready[2];
    assign s3_tready = s_tready[3];

    // Scan starts one past the previous owner; offset 4 wraps back onto last_grant itself.
    always_comb begin
        req_found  = 1'b0;
        next_grant = last_grant;
        cand       = last_grant;
        for (int unsigned i = 1; i <= 4; i++) begin
            cand = last_grant + 2'(i);
            if (!req_found && s_tvalid[cand]) begin
                req_found  = 1'b1;
                next_grant = cand;
            end
        end
    end

    always_comb begin
        m_tvalid = 1'b0;
        m_tdata  = '0;
        m_tkeep  = '0;
        m_tlast  = 1'b0;
        m_tuser  = 1'b0;
        s_tready = '0;
        if (state == PKT) begin
            m_tvalid           = s_tvalid[grant_id];
            m_tdata            = s_tdata[grant_id];
            m_tkeep            = s_tkeep[grant_id];
            m_tlast            = s_tlast[grant_id];
            m_tuser            = s_tuser[grant_id];
            s_tready[grant_id] = m_tready;
        end
    end

    assign xfer_last = (state == PKT) && m_tvalid && m_tready && m_tlast;

    always_ff @(posedge clk156 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 2'd3;
            grant_id   <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_found) begin
                        grant_id <= next_grant;
                        busy     <= 1'b1;
                        state    <= PKT;
                    end
                end
                PKT: begin
                    if (xfer_last) begin
                        last_grant <= grant_id;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef ARB_PKT_CNT_EN
    logic [3:0][31:0] pkt_cnt_q;

    always_ff @(posedge clk156 or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt_q <= '0;
        end else if (xfer_last) begin
            pkt_cnt_q[grant_id] <= pkt_cnt_q[grant_id] + 32'd1;
        end
    end

    assign pkt_cnt0 = pkt_cnt_q[0];
    assign pkt_cnt1 = pkt_cnt_q[1];
    assign pkt_cnt2 = pkt_cnt_q[2];
    assign pkt_cnt3 = pkt_cnt_q[3];
`endif

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed self-checking bench for eth_tx_arbiter; counter checks compile only with ARB_PKT_CNT_EN.
module tb_eth_tx_arbiter;

    logic        clk156 = 1'b0;
    logic        rst_n;
    logic        m_tready;
    logic [3:0]  tv, tl, tu;
    logic [63:0] td [4];
    logic [7:0]  tk [4];
    logic        s0_tready, s1_tready, s2_tready, s3_tready;
    logic [3:0]  tr;
    logic        m_tvalid, m_tlast, m_tuser, busy;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic [1:0]  grant_id;
`ifdef ARB_PKT_CNT_EN
    logic [31:0] pkt_cnt0, pkt_cnt1, pkt_cnt2, pkt_cnt3;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    assign tr = {s3_tready, s2_tready, s1_tready, s0_tready};

    always #5 clk156 = ~clk156;

    eth_tx_arbiter #(.DATA_W(64)) dut (
        .clk156(clk156), .rst_n(rst_n),
        .s0_tvalid(tv[0]), .s0_tready(s0_tready), .s0_tdata(td[0]), .s0_tkeep(tk[0]), .s0_tlast(tl[0]), .s0_tuser(tu[0]),
        .s1_tvalid(tv[1]), .s1_tready(s1_tready), .s1_tdata(td[1]), .s1_tkeep(tk[1]), .s1_tlast(tl[1]), .s1_tuser(tu[1]),
        .s2_tvalid(tv[2]), .s2_tready(s2_tready), .s2_tdata(td[2]), .s2_tkeep(tk[2]), .s2_tlast(tl[2]), .s2_tuser(tu[2]),
        .s3_tvalid(tv[3]), .s3_tready(s3_tready), .s3_tdata(td[3]), .s3_tkeep(tk[3]), .s3_tlast(tl[3]), .s3_tuser(tu[3]),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
        .m_tlast(m_tlast), .m_tuser(m_tuser),
`ifdef ARB_PKT_CNT_EN
        .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .pkt_cnt2(pkt_cnt2), .pkt_cnt3(pkt_cnt3),
`endif
        .grant_id(grant_id), .busy(busy)
    );

    task automatic clear_inputs();
        tv = '0; tl = '0; tu = '0;
        for (int i = 0; i < 4; i++) begin
            td[i] = '0;
            tk[i] = '0;
        end
    endtask

    task automatic drive(input int n, input logic v, input logic [63:0] d,
                         input logic [7:0] k, input logic l, input logic u);
        tv[n] = v; td[n] = d; tk[n] = k; tl[n] = l; tu[n] = u;
    endtask

    // Leaves the bench at the negedge where rst_n is released, inputs idle.
    task automatic do_reset();
        @(negedge clk156);
        rst_n = 1'b0;
        clear_inputs();
        m_tready = 1'b1;
        @(negedge clk156);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m_tready = 1'b1;
        clear_inputs();
        tv = 4'hF; tl = 4'hF; tu = 4'hF;
        for (int i = 0; i < 4; i++) begin
            td[i] = 64'hDEAD_BEEF_0000_0000 | 64'(i);
            tk[i] = 8'hFF;
        end
        #1;
        tests_run++;
        if (m_tvalid !== 1'b0 || m_tdata !== 64'h0 || m_tkeep !== 8'h0 || m_tlast !== 1'b0 || m_tuser !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_m_outputs: valid=%0b data=%h keep=%h last=%0b user=%0b expected all 0",
                     m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser);
        end
        tests_run++;
        if (tr !== 4'b0000 || busy !== 1'b0 || grant_id !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: tready=%b busy=%0b grant=%0d expected 0000/0/0", tr, busy, grant_id);
        end
        @(posedge clk156);
        #1;
        tests_run++;
        if (m_tvalid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_held_edge: m_tvalid=%0b busy=%0b expected 0/0", m_tvalid, busy);
        end
    endtask

    task automatic test_single_source();
        do_reset();
        drive(2, 1'b1, 64'hA0A0_0000_0000_0001, 8'hFF, 1'b0, 1'b0);
        #1;
        tests_run++;
        if (m_tvalid !== 1'b0 || s2_tready !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_idle: m_tvalid=%0b s2_tready=%0b expected 0/0", m_tvalid, s2_tready);
        end
        @(negedge clk156);
        #1;
        tests_run++;
        if (grant_id !== 2'd2 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_grant: grant=%0d busy=%0b expected 2/1", grant_id, busy);
        end
        tests_run++;
        if (m_tvalid !== 1'b1 || m_tdata !== 64'hA0A0_0000_0000_0001 || m_tkeep !== 8'hFF || tr !== 4'b0100) begin
            tests_failed++;
            $display("FAIL single_beat0: valid=%0b data=%h keep=%h tready=%b expected 1/a0a0000000000001/ff/0100",
                     m_tvalid, m_tdata, m_tkeep, tr);
        end
        @(negedge clk156);
        drive(2, 1'b1, 64'hA0A0_0000_0000_0002, 8'hFF, 1'b0, 1'b0);
        #1;
        tests_run++;
        if (m_tdata !== 64'hA0A0_0000_0000_0002 || m_tkeep !== 8'hFF || m_tlast !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_beat1: data=%h keep=%h last=%0b expected a0a0000000000002/ff/0", m_tdata, m_tkeep, m_tlast);
        end
        @(negedge clk156);
        drive(2, 1'b1, 64'hA0A0_0000_0000_0003, 8'h0F, 1'b1, 1'b0);
        #1;
        tests_run++;
        if (m_tdata !== 64'hA0A0_0000_0000_0003 || m_tkeep !== 8'h0F || m_tlast !== 1'b1 || m_tvalid !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_beat2: valid=%0b data=%h keep=%h last=%0b expected 1/a0a0000000000003/0f/1",
                     m_tvalid, m_tdata, m_tkeep, m_tlast);
        end
        @(negedge clk156);
        drive(2, 1'b0, 64'h0, 8'h00, 1'b0, 1'b0);
        #1;
        tests_run++;
        if (busy !== 1'b0 || m_tvalid !== 1'b0 || grant_id !== 2'd2) begin
            tests_failed++;
            $display("FAIL single_after: busy=%0b m_tvalid=%0b grant=%0d expected 0/0/2", busy, m_tvalid, grant_id);
        end
    endtask

    // All four sources stream 2-beat packets; expected pattern repeats every 3 cycles: bubble, beat0, beat1.
    task automatic test_round_robin();
        int beat [4];
        int pkt  [4];
        logic [3:0] fire;
        int ph, pn, es, ep;
        logic [63:0] ed;
        for (int n = 0; n < 4; n++) begin
            beat[n] = 0;
            pkt[n]  = 0;
        end
        do_reset();
        for (int c = 0; c < 15; c++) begin
            if (c > 0) @(negedge clk156);
            for (int n = 0; n < 4; n++)
                drive(n, 1'b1, (64'(n) << 16) | (64'(pkt[n]) << 8) | 64'(beat[n]), 8'hFF, beat[n] == 1, 1'b0);
            #1;
            ph = c % 3;
            pn = c / 3;
            es = pn % 4;
            ep = pn / 4;
            ed = (64'(es) << 16) | (64'(ep) << 8) | 64'(ph - 1);
            tests_run++;
            if (ph == 0) begin
                if (m_tvalid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL rr_bubble c%0d: m_tvalid=%0b expected 0", c, m_tvalid);
                end
            end else if (m_tvalid !== 1'b1 || grant_id !== 2'(es) || m_tdata !== ed || m_tlast !== (ph == 2)) begin
                tests_failed++;
                $display("FAIL rr_beat c%0d: valid=%0b grant=%0d data=%h last=%0b expected 1/%0d/%h/%0b",
                         c, m_tvalid, grant_id, m_tdata, m_tlast, es, ed, ph == 2);
            end
            fire = tv & tr;
            @(posedge clk156);
            for (int n = 0; n < 4; n++) begin
                if (fire[n]) begin
                    if (beat[n] == 1) begin
                        beat[n] = 0;
                        pkt[n]++;
                    end else begin
                        beat[n] = 1;
                    end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int xfers = 0;
        do_reset();
        drive(1, 1'b1, 64'h1111_0000_0000_000A, 8'hFF, 1'b0, 1'b0);
        #1;
        @(negedge clk156);
        drive(3, 1'b1, 64'h3333_0000_0000_00F0, 8'h01, 1'b1, 1'b1);
        #1;
        tests_run++;
        if (grant_id !== 2'd1 || m_tdata !== 64'h1111_0000_0000_000A || tr !== 4'b0010) begin
            tests_failed++;
            $display("FAIL bp_grant: grant=%0d data=%h tready=%b expected 1/111100000000000a/0010", grant_id, m_tdata, tr);
        end
        if (m_tvalid && m_tready) xfers++;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk156);
            drive(1, 1'b1, 64'h1111_0000_0000_000B, 8'hFF, 1'b0, 1'b0);
            m_tready = 1'b0;
            #1;
            tests_run++;
            if (m_tvalid !== 1'b1 || m_tdata !== 64'h1111_0000_0000_000B || tr !== 4'b0000) begin
                tests_failed++;
                $display("FAIL bp_stall%0d: valid=%0b data=%h tready=%b expected 1/111100000000000b/0000", c, m_tvalid, m_tdata, tr);
            end
            if (m_tvalid && m_tready) xfers++;
        end
        @(negedge clk156);
        m_tready = 1'b1;
        #1;
        tests_run++;
        if (m_tdata !== 64'h1111_0000_0000_000B || s1_tready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_resume: data=%h s1_tready=%0b expected 111100000000000b/1", m_tdata, s1_tready);
        end
        if (m_tvalid && m_tready) xfers++;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk156);
            tv[1] = 1'b0;
            #1;
            tests_run++;
            if (m_tvalid !== 1'b0 || grant_id !== 2'd1 || busy !== 1'b1 || s3_tready !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_gap%0d: valid=%0b grant=%0d busy=%0b s3_tready=%0b expected 0/1/1/0",
                         c, m_tvalid, grant_id, busy, s3_tready);
            end
            if (m_tvalid && m_tready) xfers++;
        end
        @(negedge clk156);
        drive(1, 1'b1, 64'h1111_0000_0000_000C, 8'h03, 1'b1, 1'b0);
        #1;
        tests_run++;
        if (m_tvalid !== 1'b1 || m_tdata !== 64'h1111_0000_0000_000C || m_tlast !== 1'b1 || grant_id !== 2'd1) begin
            tests_failed++;
            $display("FAIL bp_last: valid=%0b data=%h last=%0b grant=%0d expected 1/111100000000000c/1/1",
                     m_tvalid, m_tdata, m_tlast, grant_id);
        end
        if (m_tvalid && m_tready) xfers++;
        @(negedge clk156);
        tv[1] = 1'b0;
        #1;
        tests_run++;
        if (m_tvalid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_bubble: valid=%0b busy=%0b expected 0/0", m_tvalid, busy);
        end
        @(negedge clk156);
        #1;
        tests_run++;
        if (grant_id !== 2'd3 || m_tdata !== 64'h3333_0000_0000_00F0 || m_tlast !== 1'b1 || m_tuser !== 1'b1 || m_tkeep !== 8'h01) begin
            tests_failed++;
            $display("FAIL bp_s3: grant=%0d data=%h last=%0b user=%0b keep=%h expected 3/33330000000000f0/1/1/01",
                     grant_id, m_tdata, m_tlast, m_tuser, m_tkeep);
        end
        if (m_tvalid && m_tready) xfers++;
        @(negedge clk156);
        tv[3] = 1'b0;
        #1;
        tests_run++;
        if (xfers !== 4 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_count: transfers=%0d busy=%0b expected 4/0", xfers, busy);
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        drive(0, 1'b1, 64'h0000_0000_0000_00A1, 8'hFF, 1'b0, 1'b0);
        @(negedge clk156);
        #1;
        tests_run++;
        if (grant_id !== 2'd0 || m_tvalid !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_mid_grant: grant=%0d valid=%0b expected 0/1", grant_id, m_tvalid);
        end
        @(negedge clk156);
        drive(0, 1'b1, 64'h0000_0000_0000_00A2, 8'hFF, 1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (m_tvalid !== 1'b0 || m_tdata !== 64'h0 || m_tlast !== 1'b0 || m_tuser !== 1'b0 || tr !== 4'b0000
            || busy !== 1'b0 || grant_id !== 2'd0) begin
            tests_failed++;
            $display("FAIL rst_mid_outputs: valid=%0b data=%h last=%0b user=%0b tready=%b busy=%0b grant=%0d expected all 0",
                     m_tvalid, m_tdata, m_tlast, m_tuser, tr, busy, grant_id);
        end
        @(negedge clk156);
        rst_n = 1'b1;
        drive(0, 1'b1, 64'h0000_0000_0000_00E0, 8'hFF, 1'b1, 1'b0);
        drive(1, 1'b1, 64'h0000_0000_0000_00F1, 8'hFF, 1'b1, 1'b0);
        #1;
        tests_run++;
        if (m_tvalid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_release_idle: valid=%0b busy=%0b expected 0/0", m_tvalid, busy);
        end
        @(negedge clk156);
        #1;
        tests_run++;
        if (grant_id !== 2'd0 || m_tdata !== 64'h0000_0000_0000_00E0 || m_tvalid !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_first_grant: grant=%0d data=%h valid=%0b expected 0/00000000000000e0/1", grant_id, m_tdata, m_tvalid);
        end
        @(negedge clk156);
        tv[0] = 1'b0;
        @(negedge clk156);
        #1;
        tests_run++;
        if (grant_id !== 2'd1 || m_tdata !== 64'h0000_0000_0000_00F1) begin
            tests_failed++;
            $display("FAIL rst_second_grant: grant=%0d data=%h expected 1/00000000000000f1", grant_id, m_tdata);
        end
        @(negedge clk156);
        tv[1] = 1'b0;
    endtask

`ifdef ARB_PKT_CNT_EN
    task automatic test_pkt_cnt();
        do_reset();
        force dut.pkt_cnt_q[1] = 32'hFFFF_FFFF;
        @(negedge clk156);
        release dut.pkt_cnt_q[1];
        drive(1, 1'b1, 64'h5555_0000_0000_0001, 8'hFF, 1'b0, 1'b1);
        @(negedge clk156);
        @(negedge clk156);
        drive(1, 1'b1, 64'h5555_0000_0000_0002, 8'hFF, 1'b1, 1'b1);
        #1;
        tests_run++;
        if (m_tuser !== 1'b1 || m_tlast !== 1'b1) begin
            tests_failed++;
            $display("FAIL cnt_tuser: user=%0b last=%0b expected 1/1", m_tuser, m_tlast);
        end
        @(negedge clk156);
        tv[1] = 1'b0;
        #1;
        tests_run++;
        if (pkt_cnt1 !== 32'h0 || pkt_cnt0 !== 32'h0) begin
            tests_failed++;
            $display("FAIL cnt_wrap: pkt_cnt1=%h pkt_cnt0=%h expected 0/0", pkt_cnt1, pkt_cnt0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_source();
        test_round_robin();
        test_backpressure();
        test_reset_mid_packet();
`ifdef ARB_PKT_CNT_EN
        test_pkt_cnt();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/eth_tx_arbiter.md
ETH_TX_ARBITER -- requirements
Module: eth_tx_arbiter

Interface
REQ-001 SHALL have parameter: DATA_W, 64, stream data width in bits; KEEP_W is fixed at DATA_W/8.
REQ-002 SHALL have port: clk156  input  1  single clock for all logic.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports, for N in 0..3: sN_tvalid in 1, sN_tready out 1, sN_tdata in DATA_W, sN_tkeep in KEEP_W, sN_tlast in 1, sN_tuser in 1; AXI-Stream requester N.
REQ-005 SHALL have ports: m_tvalid out 1, m_tready in 1, m_tdata out DATA_W, m_tkeep out KEEP_W, m_tlast out 1, m_tuser out 1; shared PHY TX stream.
REQ-006 SHALL have ports: grant_id out 2, index of the granted requester; busy out 1, high while a packet is owned.
REQ-007 SHALL have ports, only with ARB_PKT_CNT_EN: pkt_cntN out 32, N in 0..3, packets forwarded per requester.

Function
REQ-008 SHALL be a two-state FSM: IDLE, PKT.
REQ-009 In IDLE: m_tvalid=0, all sN_tready=0, busy=0; m_tdata/m_tkeep/m_tlast/m_tuser SHALL be 0.
REQ-010 In IDLE with any sN_tvalid=1: grant SHALL register on that clock edge to the first requesting N scanning from (last_grant+1) mod 4 upward with wrap; state -> PKT.
REQ-011 Arbitration latency SHALL be exactly 1 cycle: first beat is presentable on m_* the cycle after the edge that sets the grant.
REQ-012 In PKT: m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser SHALL combinationally equal those of s[grant_id]; s[grant_id]_tready SHALL equal m_tready; all other sN_tready SHALL be 0; busy=1.
REQ-013 A beat SHALL transfer only when m_tvalid and m_tready are both 1.
REQ-014 On transfer of a beat with m_tlast=1: state -> IDLE, last_grant <= grant_id.
REQ-015 Grant SHALL be held for the whole packet; requests from other ports SHALL not preempt it.
REQ-016 If the granted requester drops tvalid mid-packet, grant SHALL be held and m_tvalid SHALL be 0 until it resumes; no timeout.
REQ-017 tlast presented while m_tready=0 SHALL hold state PKT until transferred.
REQ-018 Single-beat packets (tvalid and tlast on first beat) SHALL take one PKT cycle when m_tready=1.
REQ-019 Back-to-back packets SHALL incur exactly one IDLE bubble cycle between the last beat of one and the first beat of the next.
REQ-020 With all four requesting continuously, grant order SHALL be 0,1,2,3,0,... one packet each.
REQ-021 m_tuser SHALL pass through unmodified; arbiter SHALL not drop or alter packets.
REQ-022 grant_id SHALL retain its last value in IDLE.

Reset
REQ-023 rst_n=0 SHALL immediately force: state IDLE, last_grant=3 (port 0 first), grant_id=0, busy=0, all sN_tready=0, all m_* outputs 0, pkt_cntN=0.
REQ-024 Reset asserted mid-packet SHALL abandon the packet with no tlast emitted; after release the arbiter SHALL resume from IDLE.
REQ-025 Reset release SHALL be taken synchronously by clk156; first grant no earlier than the first edge after release.

Configuration
REQ-026 Macro ARB_PKT_CNT_EN defined: pkt_cntN ports exist; pkt_cntN increments by 1 on each transferred tlast beat from requester N, wrapping 0xFFFFFFFF -> 0, regardless of tuser.
REQ-027 Macro ARB_PKT_CNT_EN undefined: pkt_cntN ports and counters absent; all other behaviour identical.

Verification
REQ-028 Reset, then s2 sends 3-beat packet, m_tready=1 -> grant_id=2, beats on m_* cycles 2..4 after request edge, tkeep 0xFF,0xFF,0x0F preserved, busy low after.
REQ-029 s0..s3 all request 2-beat packets continuously -> m_* order 0,1,2,3,0 with one bubble between packets.
REQ-030 s1 packet in flight, m_tready toggles 1,0,0,1 and s1_tvalid drops for 2 cycles -> no beat lost/duplicated, s3 request ignored until s1 tlast transfers, then grant_id=3.
REQ-031 rst_n pulsed low mid-packet on s0 -> all outputs 0 same cycle; after release s1 and s0 request -> s0 granted first.
REQ-032 ARB_PKT_CNT_EN defined, pkt_cnt1 preloaded via forcing to 0xFFFFFFFF, s1 sends one packet with tuser=1 -> pkt_cnt1=0, m_tuser=1 on last beat; undefined build compiles without pkt_cnt ports.
